dp_dmi_dr: RTL and testbench

//  DMI data register of the debug transport module: W-bit capture/shift/update register feeding sdi[SEL_DMI] of the DR mux.

---
 rtl/dp_dmi_dr_pkg.sv | 21 ++
 rtl/dp_dmi_dr_shreg.sv | 34 +++
 rtl/dp_dmi_dr.sv | 123 ++++++++++++
 tb/tb_dp_dmi_dr.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_dmi_dr_pkg.sv
// Shared constants and types for the DMI data register.
package dp_dmi_dr_pkg;

  localparam int DMI_ABITS = 7;
  localparam int DMI_W     = DMI_ABITS + 34;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_ST_OK   = 2'd0;
  localparam logic [1:0] DMI_ST_FAIL = 2'd2;
  localparam logic [1:0] DMI_ST_BUSY = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} dmi_state_t;

  function automatic logic isReqOp(input logic [1:0] op);
    return (op == DMI_OP_READ) || (op == DMI_OP_WRITE);
  endfunction

endpackage

// File: rtl/dp_dmi_dr_shreg.sv
// W-bit capture/shift register; shifts LSB first and presents bit 0 on sdo.
module dp_dmi_dr_shreg #(
  parameter int W = 41
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_tdi,
  input  logic         i_capture,
  input  logic         i_shift,
  input  logic         i_clk_dr,
  input  logic [W-1:0] i_cap_data,
  output logic [W-1:0] o_shreg,
  output logic         o_sdo
);

  logic [W-1:0] r_shreg;

  // Capture takes priority when the TAP flags overlap.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_shreg <= '0;
    end else if (i_clk_dr) begin
      if (i_capture) begin
        r_shreg <= i_cap_data;
      end else if (i_shift) begin
        r_shreg <= {i_tdi, r_shreg[W-1:1]};
      end
    end
  end

  assign o_shreg = r_shreg;
  assign o_sdo   = r_shreg[0];

endmodule

// File: rtl/dp_dmi_dr.sv
// DMI data register: turns DR updates into DM bus requests and keeps sticky dmistat.
module dp_dmi_dr
  import dp_dmi_dr_pkg::*;
#(
  parameter int ABITS = DMI_ABITS,
  parameter int W     = ABITS + 34
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_tdi,
  input  logic             i_capture_dr,
  input  logic             i_shift_dr,
  input  logic             i_clk_dr,
  input  logic             i_update_dr,
  output logic             o_sdo,
  input  logic             i_dmireset,
  input  logic             i_dmihardreset,
  output logic [1:0]       o_dmistat,
  output logic             o_req_valid,
  input  logic             i_req_ready,
  output logic [ABITS-1:0] o_req_addr,
  output logic [31:0]      o_req_data,
  output logic [1:0]       o_req_op,
  input  logic             i_rsp_valid,
  input  logic [31:0]      i_rsp_data,
  input  logic [1:0]       i_rsp_resp
);

  dmi_state_t       r_state, w_next_state;
  logic [1:0]       r_dmistat;
  logic [ABITS-1:0] r_req_addr, r_last_addr;
  logic [31:0]      r_req_data, r_last_data;
  logic [1:0]       r_req_op;

  logic [W-1:0]     w_shreg, w_cap_data;
  logic [ABITS-1:0] w_upd_addr;
  logic [31:0]      w_upd_data;
  logic [1:0]       w_upd_op, w_cap_op;
  logic             w_upd_live, w_accept, w_busy_hit, w_rsp_take;

  assign w_upd_addr = w_shreg[W-1:34];
  assign w_upd_data = w_shreg[33:2];
  assign w_upd_op   = w_shreg[1:0];
  assign w_cap_op   = (r_state != IDLE) ? DMI_ST_BUSY : r_dmistat;
  assign w_cap_data = {r_last_addr, r_last_data, w_cap_op};

  dp_dmi_dr_shreg #(.W(W)) u_shreg (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_tdi      (i_tdi),
    .i_capture  (i_capture_dr),
    .i_shift    (i_shift_dr),
    .i_clk_dr   (i_clk_dr),
    .i_cap_data (w_cap_data),
    .o_shreg    (w_shreg),
    .o_sdo      (o_sdo)
  );

  // A response arriving together with a hardreset is dropped, so WAIT never strands in DRAIN.
  always_comb begin
    w_upd_live   = i_update_dr && (r_dmistat == DMI_ST_OK);
    w_accept     = w_upd_live && (r_state == IDLE) && isReqOp(w_upd_op) && !i_dmihardreset;
    w_busy_hit   = w_upd_live && (r_state != IDLE);
    w_rsp_take   = i_rsp_valid && (r_state == WAIT) && !i_dmihardreset;
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = REQ;
      REQ:     if (i_dmihardreset) w_next_state = IDLE;
               else if (i_req_ready) w_next_state = WAIT;
      WAIT:    if (i_rsp_valid) w_next_state = IDLE;
               else if (i_dmihardreset) w_next_state = DRAIN;
      DRAIN:   if (i_rsp_valid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_dmistat <= DMI_ST_OK;
    end else if (i_dmireset || i_dmihardreset) begin
      r_dmistat <= DMI_ST_OK;
    end else if (w_busy_hit) begin
      r_dmistat <= DMI_ST_BUSY;
    end else if (w_rsp_take && (i_rsp_resp != 2'd0) && (r_dmistat == DMI_ST_OK)) begin
      r_dmistat <= DMI_ST_FAIL;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_op    <= DMI_OP_NOP;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      if (w_accept) begin
        r_req_addr  <= w_upd_addr;
        r_req_data  <= w_upd_data;
        r_req_op    <= w_upd_op;
        r_last_addr <= w_upd_addr;
      end
      if (w_rsp_take && (r_req_op == DMI_OP_READ)) begin
        r_last_data <= i_rsp_data;
      end
    end
  end

  assign o_dmistat   = r_dmistat;
  assign o_req_valid = (r_state == REQ);
  assign o_req_addr  = r_req_addr;
  assign o_req_data  = r_req_data;
  assign o_req_op    = r_req_op;

endmodule

// File: tb/tb_dp_dmi_dr.sv
// Scoreboard bench for dp_dmi_dr: DR scans and bus requests checked against a transaction-level model.
module tb_dp_dmi_dr;
  import dp_dmi_dr_pkg::*;

  localparam int AB = DMI_ABITS;
  localparam int WD = DMI_W;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          tdi = 1'b0, captureDr = 1'b0, shiftDr = 1'b0, clkDr = 1'b0, updateDr = 1'b0;
  logic          sdo;
  logic          dmiReset = 1'b0, dmiHardReset = 1'b0;
  logic [1:0]    dmiStat;
  logic          reqValid, reqReady = 1'b0;
  logic [AB-1:0] reqAddr;
  logic [31:0]   reqData;
  logic [1:0]    reqOp;
  logic          rspValid = 1'b0;
  logic [31:0]   rspData = '0;
  logic [1:0]    rspResp = '0;

  int errors = 0;
  int checks = 0;

  // Model: 0 idle, 1 request pending, 2 awaiting response, 3 discarding response.
  int            mPhase = 0;
  logic [1:0]    mStat = 0;
  logic [AB-1:0] mLastAddr = 0;
  logic [31:0]   mLastData = 0;
  logic [1:0]    mReqOp = 0;
  logic [WD-1:0] reqQ[$];
  logic [WD-1:0] capQ[$];

  logic [WD-1:0] shotBits = '0;
  int            bitCnt = 0;

  always #5 clk = ~clk;

  dp_dmi_dr dut (
    .i_clk(clk), .i_resetn(resetn), .i_tdi(tdi), .i_capture_dr(captureDr),
    .i_shift_dr(shiftDr), .i_clk_dr(clkDr), .i_update_dr(updateDr), .o_sdo(sdo),
    .i_dmireset(dmiReset), .i_dmihardreset(dmiHardReset), .o_dmistat(dmiStat),
    .o_req_valid(reqValid), .i_req_ready(reqReady), .o_req_addr(reqAddr),
    .o_req_data(reqData), .o_req_op(reqOp), .i_rsp_valid(rspValid),
    .i_rsp_data(rspData), .i_rsp_resp(rspResp)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scan monitor: rebuilds each shifted-out DR word from sdo and checks it against the capture queue.
  always @(negedge clk) begin
    if (resetn && clkDr && captureDr) begin
      bitCnt = 0;
    end else if (resetn && clkDr && shiftDr) begin
      shotBits[bitCnt] = sdo;
      bitCnt++;
      if (bitCnt == WD) begin
        bitCnt = 0;
        if (capQ.size() == 0) checkOutput("capture_unexpected", shotBits, '0);
        else checkOutput("capture_word", shotBits, capQ.pop_front());
      end
    end
  end

  // Bus monitor: every accepted request must match the oldest expected request.
  always @(negedge clk) begin
    if (resetn && reqValid && reqReady) begin
      if (reqQ.size() == 0) checkOutput("req_unexpected", {reqAddr, reqData, reqOp}, '0);
      else checkOutput("req_fields", {reqAddr, reqData, reqOp}, reqQ.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_dmistat"}, dmiStat, mStat);
    checkOutput({tag, "_req_valid"}, reqValid, (mPhase == 1));
  endtask

  // Capture, scan in {addr,data,op}, then optionally update.
  task automatic applyStimulus(input logic [AB-1:0] addr, input logic [31:0] data,
                               input logic [1:0] op, input bit doUpdate);
    logic [WD-1:0] word;
    word = {addr, data, op};
    step();
    captureDr = 1'b1;
    clkDr = 1'b1;
    capQ.push_back({mLastAddr, mLastData, (mPhase != 0) ? 2'd3 : mStat});
    for (int i = 0; i < WD; i++) begin
      step();
      captureDr = 1'b0;
      shiftDr = 1'b1;
      tdi = word[i];
    end
    step();
    shiftDr = 1'b0;
    clkDr = 1'b0;
    if (doUpdate) begin
      updateDr = 1'b1;
      if (mStat == 0) begin
        if (mPhase != 0) begin
          mStat = 2'd3;
        end else if (op == 2'd1 || op == 2'd2) begin
          mPhase = 1;
          mLastAddr = addr;
          mReqOp = op;
          reqQ.push_back(word);
        end
      end
    end
    step();
    updateDr = 1'b0;
    checkState("after_update");
  endtask

  task automatic acceptReq(input int holdCycles);
    for (int i = 0; i < holdCycles; i++) begin
      step();
      checkState("hold");
    end
    step();
    reqReady = 1'b1;
    if (mPhase == 1) mPhase = 2;
    step();
    reqReady = 1'b0;
  endtask

  task automatic sendRsp(input logic [31:0] data, input logic [1:0] resp);
    step();
    rspValid = 1'b1;
    rspData = data;
    rspResp = resp;
    if (mPhase == 2) begin
      if (mReqOp == 2'd1) mLastData = data;
      if (resp != 2'd0 && mStat == 2'd0) mStat = 2'd2;
      mPhase = 0;
    end else if (mPhase == 3) begin
      mPhase = 0;
    end
    step();
    rspValid = 1'b0;
  endtask

  task automatic pulseDmiReset();
    step();
    dmiReset = 1'b1;
    mStat = 0;
    step();
    dmiReset = 1'b0;
  endtask

  task automatic pulseHardReset();
    step();
    dmiHardReset = 1'b1;
    mStat = 0;
    if (mPhase == 1) begin
      mPhase = 0;
      reqQ.delete();
    end else if (mPhase == 2) begin
      mPhase = 3;
    end
    step();
    dmiHardReset = 1'b0;
  endtask

  task automatic doReset();
    step();
    resetn = 1'b0;
    mPhase = 0;
    mStat = 0;
    mLastAddr = 0;
    mLastData = 0;
    mReqOp = 0;
    reqQ.delete();
    step();
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("reset_sdo", sdo, 1'b0);
    checkOutput("reset_dmistat", dmiStat, 2'd0);
    checkOutput("reset_req_valid", reqValid, 1'b0);
    checkOutput("reset_req_fields", {reqAddr, reqData, reqOp}, '0);
  endtask

  initial begin
    logic [1:0] op;
    doReset();
    applyStimulus('0, '0, 2'd0, 1'b0);

    // Write then confirm capture shows the written address and ok status.
    applyStimulus(7'h10, 32'hDEADBEEF, 2'd2, 1'b1);
    acceptReq(3);
    sendRsp(32'h0, 2'd0);
    checkState("write_done");
    applyStimulus('0, '0, 2'd0, 1'b1);

    // Read data appears in the next capture.
    applyStimulus(7'h11, 32'h0, 2'd1, 1'b1);
    acceptReq(1);
    sendRsp(32'h12345678, 2'd0);
    applyStimulus('0, '0, 2'd0, 1'b0);

    // Busy: second update while the first is still pending.
    applyStimulus(7'h22, 32'hA5A5A5A5, 2'd2, 1'b1);
    applyStimulus(7'h23, 32'h1, 2'd1, 1'b1);
    acceptReq(2);
    sendRsp(32'h0, 2'd0);
    applyStimulus(7'h24, 32'h2, 2'd2, 1'b1);
    pulseDmiReset();
    checkState("busy_cleared");

    // Failure response sets sticky status and blocks the next request.
    applyStimulus(7'h30, 32'h0, 2'd1, 1'b1);
    acceptReq(0);
    sendRsp(32'h55AA55AA, 2'd2);
    checkState("fail");
    applyStimulus(7'h31, 32'h0, 2'd1, 1'b1);
    pulseDmiReset();
    checkState("fail_cleared");

    // Hardreset in WAIT discards the late response.
    applyStimulus(7'h40, 32'h0, 2'd1, 1'b1);
    acceptReq(1);
    pulseHardReset();
    applyStimulus('0, '0, 2'd0, 1'b0);
    sendRsp(32'hCAFE0000, 2'd0);
    applyStimulus('0, '0, 2'd0, 1'b0);

    // Reset while a request is pending.
    applyStimulus(7'h50, 32'h13579BDF, 2'd2, 1'b1);
    doReset();
    applyStimulus('0, '0, 2'd0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      applyStimulus(AB'($urandom), $urandom, op, 1'b1);
      if (mPhase == 1) begin
        if ($urandom_range(0, 3) == 0) applyStimulus(AB'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'b1);
        if ($urandom_range(0, 5) == 0) begin
          pulseHardReset();
        end else begin
          acceptReq($urandom_range(0, 3));
          if ($urandom_range(0, 4) == 0) pulseHardReset();
          sendRsp($urandom, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        sendRsp($urandom, 2'd2);
      end
      checkState("random");
      if (mStat != 0 && $urandom_range(0, 1) == 1) pulseDmiReset();
    end
    applyStimulus('0, '0, 2'd0, 1'b0);

    step();
    step();
    checkOutput("req_queue_drained", reqQ.size(), 0);
    checkOutput("capture_queue_drained", capQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
